seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan_pkg.sv | 27 ++
 rtl/seg_scan_dec.sv | 33 +++
 rtl/seg_scan.sv | 119 +++++++++++
 tb/tb_seg_scan.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the seven-segment display blocks.
// Latency: none (declarations only).
// Backpressure: none.
package seg_scan_pkg;

    // Active-low "everything off" patterns shared by all display blocks
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [3:0] DIG_NONE = 4'hF;

    // One complete frame's worth of display content
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        blank_lz;
    } disp_t;

    // Bit i set when nibbles 3..i are all zero; digit 0 is never a leading zero
    function automatic logic [3:0] lead_zero(input logic [15:0] v);
        logic [3:0] lz;
        lz[3] = (v[15:12] == 4'h0);
        lz[2] = lz[3] && (v[11:8] == 4'h0);
        lz[1] = lz[2] && (v[7:4] == 4'h0);
        lz[0] = 1'b0;
        return lz;
    endfunction

endpackage

// File: rtl/seg_scan_dec.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
// Latency: combinational.
// Backpressure: none.
module seg_scan_dec (
    input  logic [3:0] bin_data,
    output logic [6:0] seg_data
);

    // Lookup of the sixteen hex glyphs (lowercase b and d)
    always_comb begin
        seg_data = 7'h7F;
        case (bin_data)
            4'h0: seg_data = 7'h40;
            4'h1: seg_data = 7'h79;
            4'h2: seg_data = 7'h24;
            4'h3: seg_data = 7'h30;
            4'h4: seg_data = 7'h19;
            4'h5: seg_data = 7'h12;
            4'h6: seg_data = 7'h02;
            4'h7: seg_data = 7'h78;
            4'h8: seg_data = 7'h00;
            4'h9: seg_data = 7'h10;
            4'hA: seg_data = 7'h08;
            4'hB: seg_data = 7'h03;
            4'hC: seg_data = 7'h46;
            4'hD: seg_data = 7'h21;
            4'hE: seg_data = 7'h06;
            4'hF: seg_data = 7'h0E;
            default: seg_data = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous update.
// Latency: outputs one cycle after scan state; loads take effect at next frame boundary.
// Backpressure: none; a newer load overwrites an unapplied one, upd_ack marks the swap.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic        upd_ack,
    output logic [6:0]  seg_data,
    output logic        dp_n,
    output logic [3:0]  dig_sel
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYC);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          tick;
    logic          frame_end;

    disp_t         shadow;
    disp_t         disp;
    disp_t         load_dat;
    logic          pending;

    logic [3:0]    cur_nib;
    logic [6:0]    cur_seg;
    logic          cur_dp;
    logic [3:0]    lz;
    logic          slot_blank;

    assign tick      = (cnt == CNT_MAX);
    assign frame_end = tick && (idx == 2'd3);
    assign load_dat  = '{value: value, dp: dp_in, blank_lz: blank_lz};

    // Prescaler and digit index: one slot per CLK_DIV cycles, four slots per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow/display double buffer; a load coinciding with the boundary bypasses the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
            upd_ack <= 1'b0;
        end else begin
            upd_ack <= 1'b0;
            if (load) begin
                shadow <= load_dat;
            end
            if (frame_end && (load || pending)) begin
                disp    <= load ? load_dat : shadow;
                pending <= 1'b0;
                upd_ack <= 1'b1;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Select the nibble and decimal point for the active slot
    always_comb begin
        cur_nib = disp.value[3:0];
        cur_dp  = disp.dp[0];
        case (idx)
            2'd0: begin cur_nib = disp.value[3:0];   cur_dp = disp.dp[0]; end
            2'd1: begin cur_nib = disp.value[7:4];   cur_dp = disp.dp[1]; end
            2'd2: begin cur_nib = disp.value[11:8];  cur_dp = disp.dp[2]; end
            2'd3: begin cur_nib = disp.value[15:12]; cur_dp = disp.dp[3]; end
            default: begin cur_nib = disp.value[3:0]; cur_dp = disp.dp[0]; end
        endcase
    end

    assign lz         = lead_zero(disp.value);
    assign slot_blank = (cnt < CNT_BLK);

    seg_scan_dec u_dec (
        .bin_data (cur_nib),
        .seg_data (cur_seg)
    );

    // Registered drive: blank window first, then the digit with optional zero suppression
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_data <= SEG_OFF;
            dp_n     <= 1'b1;
            dig_sel  <= DIG_NONE;
        end else if (slot_blank) begin
            seg_data <= SEG_OFF;
            dp_n     <= 1'b1;
            dig_sel  <= DIG_NONE;
        end else begin
            seg_data <= (disp.blank_lz && lz[idx]) ? SEG_OFF : cur_seg;
            dp_n     <= ~cur_dp;
            dig_sel  <= ~(4'b0001 << idx);
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed self-checking bench for seg_scan at CLK_DIV=8, BLANK_CYC=2.
// Latency: one frame is 32 cycles; every cycle of each frame is compared.
// Backpressure: none.
module tb_seg_scan;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        upd_ack;
    logic [6:0]  seg_data;
    logic        dp_n;
    logic [3:0]  dig_sel;

    int n_vec;
    int n_err;
    int frame_no;

    // Expected per-digit segment pattern and dp_n for the frame being checked
    logic [6:0] eseg [4];
    logic       edpn [4];

    seg_scan #(
        .CLK_DIV   (8),
        .BLANK_CYC (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .upd_ack  (upd_ack),
        .seg_data (seg_data),
        .dp_n     (dp_n),
        .dig_sel  (dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_exp(input logic [6:0] s3, input logic [6:0] s2,
                           input logic [6:0] s1, input logic [6:0] s0,
                           input logic [3:0] dpn);
        eseg[3] = s3; eseg[2] = s2; eseg[1] = s1; eseg[0] = s0;
        for (int d = 0; d < 4; d++) edpn[d] = dpn[d];
    endtask

    // One full 32-cycle frame, optionally with up to two loads at given cycle offsets
    task automatic run_frame(input bit ack_last,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input logic [3:0] dpv, input logic blz);
        logic [11:0] exp_out;
        int          di;
        for (int i = 0; i < 32; i++) begin
            if (i == la || i == lb) begin
                load     = 1'b1;
                value    = (i == la) ? va : vb;
                dp_in    = dpv;
                blank_lz = blz;
            end
            step();
            load = 1'b0;
            di = i / 8;
            if ((i % 8) < 2)
                exp_out = {4'hF, 7'h7F, 1'b1};
            else
                exp_out = {~(4'b0001 << di), eseg[di], edpn[di]};
            check_val($sformatf("f%0d_c%0d_out", frame_no, i),
                      {4'h0, dig_sel, seg_data, dp_n}, {4'h0, exp_out});
            check_val($sformatf("f%0d_c%0d_ack", frame_no, i),
                      {15'h0, upd_ack}, {15'h0, (ack_last && i == 31)});
        end
        frame_no++;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        frame_no = 0;
        rst_n    = 1'b1;
        load     = 1'b0;
        value    = 16'h0;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_out", {4'h0, dig_sel, seg_data, dp_n}, {4'h0, 4'hF, 7'h7F, 1'b1});
        check_val("rst_ack", {15'h0, upd_ack}, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: all digits show 0, first slot starts blank at digit 0
        set_exp(7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
        run_frame(0, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);

        // Mid-frame load: current frame untouched, swap at the boundary
        run_frame(1, 10, 16'h12AF, -1, 16'h0, 4'h0, 1'b0);
        set_exp(7'h79, 7'h24, 7'h08, 7'h0E, 4'hF);

        // Two loads in one frame: last wins, single ack
        run_frame(1, 5, 16'h1111, 20, 16'h2222, 4'h0, 1'b0);
        set_exp(7'h24, 7'h24, 7'h24, 7'h24, 4'hF);

        // Leading-zero blanking
        run_frame(1, 3, 16'h0030, -1, 16'h0, 4'h0, 1'b1);
        set_exp(7'h7F, 7'h7F, 7'h30, 7'h40, 4'hF);
        run_frame(1, 3, 16'h0000, -1, 16'h0, 4'h0, 1'b1);
        set_exp(7'h7F, 7'h7F, 7'h7F, 7'h40, 4'hF);

        // Load exactly on the boundary cycle is applied there, with a dp on digit 2
        run_frame(1, 31, 16'h1234, -1, 16'h0, 4'b0100, 1'b0);
        set_exp(7'h79, 7'h24, 7'h30, 7'h19, 4'b1011);
        run_frame(0, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);

        // Pending load killed by a mid-frame reset
        for (int i = 0; i < 12; i++) begin
            if (i == 5) begin
                load  = 1'b1;
                value = 16'h8888;
                dp_in = 4'hF;
            end
            step();
            load = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_val("midrst_out", {4'h0, dig_sel, seg_data, dp_n}, {4'h0, 4'hF, 7'h7F, 1'b1});
        check_val("midrst_ack", {15'h0, upd_ack}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_exp(7'h40, 7'h40, 7'h40, 7'h40, 4'hF);
        run_frame(0, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);
        run_frame(0, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
